// File: rtl/ysyx_22040895_mem_arbiter_if.sv
// Signal bundle between the IFU, the LSU, the shared memory port and the arbiter.
// The arbiter uses the slave view; requesters and memory use the master view.
interface ysyx_22040895_mem_arbiter_if;
   logic        ifu_req_valid_i;
   logic [63:0] ifu_addr_i;
   logic        ifu_req_ready_o;
   logic        ifu_rsp_valid_o;
   logic [31:0] ifu_inst_o;

   logic        lsu_req_valid_i;
   logic        lsu_wen_i;
   logic [63:0] lsu_addr_i;
   logic [63:0] lsu_wdata_i;
   logic [7:0]  lsu_wmask_i;
   logic        lsu_req_ready_o;
   logic        lsu_rsp_valid_o;
   logic [63:0] lsu_rdata_o;

   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic        mem_wen_o;
   logic [63:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_wmask_o;
   logic        mem_rsp_valid_i;
   logic [63:0] mem_rdata_i;

   modport slave (
      input  ifu_req_valid_i, ifu_addr_i,
      output ifu_req_ready_o, ifu_rsp_valid_o, ifu_inst_o,
      input  lsu_req_valid_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
      output lsu_req_ready_o, lsu_rsp_valid_o, lsu_rdata_o,
      output mem_req_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
      input  mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
   );

   modport master (
      output ifu_req_valid_i, ifu_addr_i,
      input  ifu_req_ready_o, ifu_rsp_valid_o, ifu_inst_o,
      output lsu_req_valid_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
      input  lsu_req_ready_o, lsu_rsp_valid_o, lsu_rdata_o,
      input  mem_req_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
      output mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
   );
endinterface

// File: rtl/ysyx_22040895_mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for a single shared memory port, one transaction
// in flight. LSU has priority, but the IFU is forced through after a bounded LSU streak.
module ysyx_22040895_mem_arbiter #(
   parameter int unsigned MAX_LSU_STREAK = 4
) (
   input logic                        clk,
   input logic                        rst,
   ysyx_22040895_mem_arbiter_if.slave bus
);

   localparam int unsigned STREAK_W = (MAX_LSU_STREAK < 1) ? 1 : $clog2(MAX_LSU_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                owner_lsu_q, owner_lsu_d;
   logic                wen_q, wen_d;
   logic [63:0]         addr_q, addr_d;
   logic [63:0]         wdata_q, wdata_d;
   logic [7:0]          wmask_q, wmask_d;
   logic [STREAK_W-1:0] streak_q, streak_d;

   logic grant_ifu;
   logic grant_lsu;
   logic ifu_forced;
   logic rsp_fire;

   // Grants are only offered from IDLE and never while reset is held.
   always_comb begin
      grant_ifu  = 1'b0;
      grant_lsu  = 1'b0;
      ifu_forced = bus.ifu_req_valid_i && (streak_q == STREAK_MAX);
      if (rst && (state_q == ST_IDLE)) begin
         if (bus.lsu_req_valid_i && !ifu_forced) begin
            grant_lsu = 1'b1;
         end else if (bus.ifu_req_valid_i) begin
            grant_ifu = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (grant_ifu || grant_lsu) state_d = ST_REQ;
         ST_REQ:  if (bus.mem_req_ready_i)    state_d = ST_RSP;
         ST_RSP:  if (bus.mem_rsp_valid_i)    state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      owner_lsu_d = owner_lsu_q;
      wen_d       = wen_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      streak_d    = streak_q;

      if (grant_lsu) begin
         owner_lsu_d = 1'b1;
         wen_d       = bus.lsu_wen_i;
         addr_d      = bus.lsu_addr_i;
         wdata_d     = bus.lsu_wdata_i;
         wmask_d     = bus.lsu_wmask_i;
      end else if (grant_ifu) begin
         owner_lsu_d = 1'b0;
         wen_d       = 1'b0;
         addr_d      = bus.ifu_addr_i;
         wdata_d     = '0;
         wmask_d     = '0;
      end

      // The streak only counts LSU wins that actually made the IFU wait.
      if (rst && (state_q == ST_IDLE)) begin
         if (!bus.ifu_req_valid_i || grant_ifu) begin
            streak_d = '0;
         end else if (grant_lsu && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_lsu_q <= 1'b0;
         wen_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         streak_q    <= '0;
      end else begin
         owner_lsu_q <= owner_lsu_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         streak_q    <= streak_d;
      end
   end

   always_comb begin
      bus.ifu_req_ready_o = grant_ifu;
      bus.lsu_req_ready_o = grant_lsu;

      bus.mem_req_valid_o = (state_q == ST_REQ);
      bus.mem_wen_o       = wen_q;
      bus.mem_addr_o      = addr_q;
      bus.mem_wdata_o     = wdata_q;
      bus.mem_wmask_o     = wmask_q;

      rsp_fire            = (state_q == ST_RSP) && bus.mem_rsp_valid_i;
      bus.ifu_rsp_valid_o = rsp_fire && !owner_lsu_q;
      bus.lsu_rsp_valid_o = rsp_fire && owner_lsu_q;

      bus.ifu_inst_o  = '0;
      bus.lsu_rdata_o = '0;
      // A 64-bit beat carries two instructions; address bit 2 picks the half.
      if (rsp_fire && !owner_lsu_q) begin
         bus.ifu_inst_o = addr_q[2] ? bus.mem_rdata_i[63:32] : bus.mem_rdata_i[31:0];
      end
      if (rsp_fire && owner_lsu_q) begin
         bus.lsu_rdata_o = bus.mem_rdata_i;
      end
   end

endmodule

// File: tb/tb_ysyx_22040895_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: transaction-level reference model feeding
// scoreboard queues, a monitor that drains them, directed scenarios then random traffic.
module tb_ysyx_22040895_mem_arbiter;
   localparam int MAX = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_22040895_mem_arbiter_if bus();

   ysyx_22040895_mem_arbiter #(.MAX_LSU_STREAK(MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic        wen;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } mreq_t;

   typedef struct packed {
      logic        own_lsu;
      logic [63:0] addr;
   } txn_t;

   int    n_err = 0;
   int    n_chk = 0;
   mreq_t exp_req_q[$];
   txn_t  exp_rsp_q[$];
   txn_t  pend[$];
   logic  pend_acc;
   int    streak_m;
   logic  log_en = 1'b0;
   logic  grant_log[$];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: DUT output with no expected entry queued", name);
   endtask

   function automatic logic [255:0] all_outputs();
      return 256'({bus.ifu_req_ready_o, bus.ifu_rsp_valid_o, bus.ifu_inst_o,
                   bus.lsu_req_ready_o, bus.lsu_rsp_valid_o, bus.lsu_rdata_o,
                   bus.mem_req_valid_o, bus.mem_wen_o, bus.mem_addr_o,
                   bus.mem_wdata_o, bus.mem_wmask_o});
   endfunction

   // Reference model: one transaction at a time, arbitration from the priority rules.
   initial begin : model
      logic       g_lsu, g_ifu;
      logic [4:0] exp_ctl, act_ctl;
      txn_t       t;
      mreq_t      r;
      streak_m = 0;
      pend_acc = 1'b0;
      forever begin
         @(negedge clk);
         act_ctl = {bus.ifu_req_ready_o, bus.lsu_req_ready_o, bus.mem_req_valid_o,
                    bus.ifu_rsp_valid_o, bus.lsu_rsp_valid_o};
         exp_ctl = '0;
         if (!rst) begin
            pend.delete();
            exp_req_q.delete();
            exp_rsp_q.delete();
            streak_m = 0;
            check("reset_outputs", all_outputs(), 256'(0));
         end else begin
            if (pend.size() == 0) begin
               g_lsu = bus.lsu_req_valid_i && !(bus.ifu_req_valid_i && streak_m == MAX);
               g_ifu = !g_lsu && bus.ifu_req_valid_i;
               if (!bus.ifu_req_valid_i || g_ifu) streak_m = 0;
               else if (g_lsu) streak_m = (streak_m < MAX) ? streak_m + 1 : MAX;
               if (g_lsu || g_ifu) begin
                  t.own_lsu = g_lsu;
                  t.addr    = g_lsu ? bus.lsu_addr_i : bus.ifu_addr_i;
                  r.wen     = g_lsu ? bus.lsu_wen_i : 1'b0;
                  r.addr    = t.addr;
                  r.wdata   = g_lsu ? bus.lsu_wdata_i : 64'h0;
                  r.wmask   = g_lsu ? bus.lsu_wmask_i : 8'h0;
                  pend.push_back(t);
                  pend_acc = 1'b0;
                  exp_req_q.push_back(r);
                  exp_rsp_q.push_back(t);
               end
               exp_ctl[4] = g_ifu;
               exp_ctl[3] = g_lsu;
            end else if (!pend_acc) begin
               exp_ctl[2] = 1'b1;
               if (bus.mem_req_ready_i) pend_acc = 1'b1;
            end else if (bus.mem_rsp_valid_i) begin
               if (pend[0].own_lsu) exp_ctl[0] = 1'b1;
               else                 exp_ctl[1] = 1'b1;
               void'(pend.pop_front());
            end
            check("handshake", 256'(act_ctl), 256'(exp_ctl));
         end
      end
   end

   // Monitor: compares request fields and response data whenever the DUT presents them.
   initial begin : monitor
      mreq_t        a;
      txn_t         t;
      logic [95:0]  exp_d;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (log_en && (bus.ifu_req_ready_o || bus.lsu_req_ready_o))
               grant_log.push_back(bus.lsu_req_ready_o);
            if (bus.mem_req_valid_o) begin
               a = {bus.mem_wen_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o};
               if (exp_req_q.size() == 0) fail("mem_req_unexpected");
               else begin
                  check("mem_req_fields", 256'(a), 256'(exp_req_q[0]));
                  if (bus.mem_req_ready_i) void'(exp_req_q.pop_front());
               end
            end
            if (bus.ifu_rsp_valid_o || bus.lsu_rsp_valid_o) begin
               if (exp_rsp_q.size() == 0) fail("rsp_unexpected");
               else begin
                  t = exp_rsp_q.pop_front();
                  exp_d = {t.own_lsu ? 32'h0 :
                           (t.addr[2] ? bus.mem_rdata_i[63:32] : bus.mem_rdata_i[31:0]),
                           t.own_lsu ? bus.mem_rdata_i : 64'h0};
                  check("rsp_owner", 256'({bus.ifu_rsp_valid_o, bus.lsu_rsp_valid_o}),
                        256'({!t.own_lsu, t.own_lsu}));
                  check("rsp_data", 256'({bus.ifu_inst_o, bus.lsu_rdata_o}), 256'(exp_d));
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ifu_req_valid_i = 1'b0;
      bus.ifu_addr_i      = '0;
      bus.lsu_req_valid_i = 1'b0;
      bus.lsu_wen_i       = 1'b0;
      bus.lsu_addr_i      = '0;
      bus.lsu_wdata_i     = '0;
      bus.lsu_wmask_i     = '0;
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rdata_i     = '0;
   endtask

   initial begin : stim
      logic [5:0] exp_order;
      exp_order = 6'b101111;
      rst = 1'b0;
      idle_inputs();
      repeat (3) cyc();

      // Grant in the very first cycle after reset release.
      cyc(); rst = 1'b1; idle_inputs();
      bus.lsu_req_valid_i = 1'b1; bus.lsu_addr_i = 64'h8000_0010;
      @(negedge clk); check("first_grant_after_reset", 256'(bus.lsu_req_ready_o), 256'(1));
      cyc(); idle_inputs(); bus.mem_req_ready_i = 1'b1;
      cyc(); idle_inputs(); bus.mem_rsp_valid_i = 1'b1; bus.mem_rdata_i = 64'h1122_3344_5566_7788;
      @(negedge clk); check("lsu_load_data", 256'(bus.lsu_rdata_o), 256'(64'h1122_3344_5566_7788));

      // IFU fetch of the upper instruction word, minimum latency.
      cyc(); idle_inputs();
      bus.ifu_req_valid_i = 1'b1; bus.ifu_addr_i = 64'h8000_0004;
      @(negedge clk); check("ifu_ready", 256'(bus.ifu_req_ready_o), 256'(1));
      cyc(); idle_inputs(); bus.mem_req_ready_i = 1'b1;
      @(negedge clk);
      check("ifu_mem_req", 256'({bus.mem_req_valid_o, bus.mem_addr_o}), 256'({1'b1, 64'h8000_0004}));
      cyc(); idle_inputs(); bus.mem_rsp_valid_i = 1'b1; bus.mem_rdata_i = 64'h0010_0093_0000_0013;
      @(negedge clk);
      check("ifu_inst", 256'({bus.ifu_rsp_valid_o, bus.ifu_inst_o}), 256'({1'b1, 32'h0010_0093}));

      // Both valid at IDLE: LSU wins.
      cyc(); idle_inputs();
      bus.ifu_req_valid_i = 1'b1; bus.ifu_addr_i = 64'h8000_0100;
      bus.lsu_req_valid_i = 1'b1; bus.lsu_addr_i = 64'h8000_2000;
      @(negedge clk);
      check("both_valid_grant", 256'({bus.ifu_req_ready_o, bus.lsu_req_ready_o}), 256'(2'b01));
      cyc(); idle_inputs(); bus.mem_req_ready_i = 1'b1;
      @(negedge clk); check("lsu_mem_addr", 256'(bus.mem_addr_o), 256'(64'h8000_2000));
      cyc(); idle_inputs(); bus.mem_rsp_valid_i = 1'b1; bus.mem_rdata_i = {$urandom, $urandom};
      cyc(); idle_inputs();

      // Both held valid: streak forces the IFU through after MAX LSU grants.
      log_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc(); idle_inputs();
         bus.ifu_req_valid_i = 1'b1; bus.ifu_addr_i = {$urandom, $urandom};
         bus.lsu_req_valid_i = 1'b1; bus.lsu_addr_i = {$urandom, $urandom};
         bus.mem_req_ready_i = 1'b1; bus.mem_rsp_valid_i = 1'b1;
         bus.mem_rdata_i     = {$urandom, $urandom};
      end
      @(negedge clk);
      log_en = 1'b0;
      if (grant_log.size() < 6) check("grant_count", 256'(grant_log.size()), 256'(6));
      else for (int i = 0; i < 6; i++) check("grant_order", 256'(grant_log[i]), 256'(exp_order[i]));
      for (int i = 0; i < 3; i++) begin
         cyc(); idle_inputs(); bus.mem_req_ready_i = 1'b1; bus.mem_rsp_valid_i = 1'b1;
      end

      // Stray response in IDLE, then a store held in REQ with a stray response.
      cyc(); idle_inputs(); bus.mem_rsp_valid_i = 1'b1;
      @(negedge clk);
      check("stray_rsp_idle", 256'({bus.ifu_rsp_valid_o, bus.lsu_rsp_valid_o}), 256'(0));
      cyc(); idle_inputs();
      bus.lsu_req_valid_i = 1'b1; bus.lsu_wen_i = 1'b1; bus.lsu_addr_i = 64'h8000_1000;
      bus.lsu_wdata_i = 64'hDEAD_BEEF; bus.lsu_wmask_i = 8'h0F;
      @(negedge clk); check("store_ready", 256'(bus.lsu_req_ready_o), 256'(1));
      for (int k = 0; k < 4; k++) begin
         cyc(); idle_inputs();
         bus.lsu_wen_i = 1'b0; bus.lsu_addr_i = {$urandom, $urandom};
         bus.lsu_wdata_i = {$urandom, $urandom}; bus.lsu_wmask_i = 8'hF0;
         bus.mem_req_ready_i = (k == 3);
         bus.mem_rsp_valid_i = (k == 1);
         @(negedge clk);
         check("store_req_stable",
               256'({bus.mem_req_valid_o, bus.mem_wen_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wmask_o}),
               256'({1'b1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F}));
         check("stray_rsp_req", 256'({bus.ifu_rsp_valid_o, bus.lsu_rsp_valid_o}), 256'(0));
      end
      cyc(); idle_inputs(); bus.mem_rsp_valid_i = 1'b1;
      @(negedge clk); check("store_rsp", 256'(bus.lsu_rsp_valid_o), 256'(1));

      // Reset while waiting for a response; the late response must vanish.
      cyc(); idle_inputs(); bus.ifu_req_valid_i = 1'b1; bus.ifu_addr_i = 64'h8000_0040;
      cyc(); idle_inputs(); bus.mem_req_ready_i = 1'b1;
      cyc(); idle_inputs();
      cyc(); idle_inputs(); rst = 1'b0;
      @(negedge clk); check("outputs_in_reset", all_outputs(), 256'(0));
      cyc(); idle_inputs(); rst = 1'b1; bus.mem_rsp_valid_i = 1'b1; bus.mem_rdata_i = {$urandom, $urandom};
      @(negedge clk); check("outputs_after_reset", all_outputs(), 256'(0));
      cyc(); idle_inputs(); bus.lsu_req_valid_i = 1'b1; bus.lsu_addr_i = 64'h8000_3000;
      @(negedge clk); check("idle_after_reset", 256'(bus.lsu_req_ready_o), 256'(1));
      cyc(); idle_inputs(); bus.mem_req_ready_i = 1'b1;
      cyc(); idle_inputs(); bus.mem_rsp_valid_i = 1'b1;

      // Random traffic, including stray handshakes and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         cyc();
         rst                 = ($urandom_range(0, 299) != 0);
         bus.ifu_req_valid_i = ($urandom_range(0, 4) != 0);
         bus.ifu_addr_i      = {$urandom, $urandom};
         bus.lsu_req_valid_i = ($urandom_range(0, 4) != 0);
         bus.lsu_wen_i       = 1'($urandom_range(0, 1));
         bus.lsu_addr_i      = {$urandom, $urandom};
         bus.lsu_wdata_i     = {$urandom, $urandom};
         bus.lsu_wmask_i     = 8'($urandom);
         bus.mem_req_ready_i = 1'($urandom_range(0, 1));
         bus.mem_rsp_valid_i = ($urandom_range(0, 4) < 2);
         bus.mem_rdata_i     = {$urandom, $urandom};
      end
      cyc(); rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         idle_inputs(); bus.mem_req_ready_i = 1'b1; bus.mem_rsp_valid_i = 1'b1;
         cyc();
      end
      idle_inputs();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
